// File: rtl/nv_nvdla_partition_reset_seq_if.sv
// Soft-reset handshake and partition reset fan-out bundle for the partition reset sequencer.
`timescale 1ns/1ps
interface nv_nvdla_partition_reset_seq_if #(
    parameter int NUM_PART = 4
);
    logic                soft_rst_req;
    logic                soft_rst_ack;
    logic [NUM_PART-1:0] part_rstn;
    logic                seq_busy;
    logic                all_released;

    modport master (
        output soft_rst_req,
        input  soft_rst_ack,
        input  part_rstn,
        input  seq_busy,
        input  all_released
    );

    modport slave (
        input  soft_rst_req,
        output soft_rst_ack,
        output part_rstn,
        output seq_busy,
        output all_released
    );
endinterface

// File: rtl/nv_nvdla_partition_reset_seq.sv
// Fans the synced core reset out to NUM_PART partition resets with staggered release,
// and re-runs the sequence on a software soft-reset request/ack handshake.
//
// state | meaning
// HOLD  | all partitions held in reset, counting the hold window
// REL   | releasing partitions one per STAGGER cycles
// RUN   | all released, idle; watches for a soft-reset request
// ACK   | soft sequence done, ack high until the request drops
`timescale 1ns/1ps
module nv_nvdla_partition_reset_seq #(
    parameter int NUM_PART = 4,
    parameter int HOLD_MIN = 16,
    parameter int STAGGER  = 8
) (
    input  logic                           nvdla_clk,
    input  logic                           nvdla_core_rstn,
    input  logic                           test_mode,
    nv_nvdla_partition_reset_seq_if.slave  rst_if
);

    localparam int CNT_RANGE = (HOLD_MIN > STAGGER) ? HOLD_MIN : STAGGER;
    localparam int CNT_W     = $clog2(CNT_RANGE) + 1;
    localparam int IDX_W     = (NUM_PART > 1) ? $clog2(NUM_PART) : 1;

    localparam logic [CNT_W-1:0]    HOLD_LAST      = CNT_W'(HOLD_MIN - 1);
    localparam logic [CNT_W-1:0]    HOLD_LAST_SOFT = CNT_W'(HOLD_MIN);
    localparam logic [CNT_W-1:0]    STAG_LAST      = CNT_W'(STAGGER - 1);
    localparam logic [CNT_W-1:0]    CNT_SAT        = {CNT_W{1'b1}};
    localparam logic [IDX_W-1:0]    IDX_LAST       = IDX_W'(NUM_PART - 1);
    localparam logic [NUM_PART-1:0] PART_ONE       = NUM_PART'(1);

    typedef enum logic [1:0] {HOLD, REL, RUN, ACK} state_t;

    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n, cnt_inc;
    logic [IDX_W-1:0]    idx, idx_n;
    logic [NUM_PART-1:0] part_rstn_q, part_n;
    logic                ack, ack_n;
    logic                all_rel, all_n;
    logic                soft_flow, flow_n;

    assign cnt_inc = (cnt == CNT_SAT) ? cnt : cnt + 1'b1;

    always_ff @(posedge nvdla_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state       <= HOLD;
            cnt         <= '0;
            idx         <= '0;
            part_rstn_q <= '0;
            ack         <= 1'b0;
            all_rel     <= 1'b0;
            soft_flow   <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            idx         <= idx_n;
            part_rstn_q <= part_n;
            ack         <= ack_n;
            all_rel     <= all_n;
            soft_flow   <= flow_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt_inc;
        idx_n   = idx;
        part_n  = part_rstn_q;
        ack_n   = ack;
        all_n   = all_rel;
        flow_n  = soft_flow;
        case (state)
            HOLD: begin
                // Soft-reset entry holds one cycle longer than power-on.
                if (cnt == (soft_flow ? HOLD_LAST_SOFT : HOLD_LAST)) begin
                    part_n = part_rstn_q | PART_ONE;
                    cnt_n  = '0;
                    idx_n  = IDX_W'(1);
                    if (NUM_PART == 1) begin
                        all_n   = 1'b1;
                        ack_n   = soft_flow;
                        state_n = soft_flow ? ACK : RUN;
                    end else begin
                        state_n = REL;
                    end
                end
            end
            REL: begin
                if (cnt == STAG_LAST) begin
                    part_n = part_rstn_q | (PART_ONE << idx);
                    cnt_n  = '0;
                    idx_n  = idx + 1'b1;
                    if (idx == IDX_LAST) begin
                        all_n   = 1'b1;
                        ack_n   = soft_flow;
                        state_n = soft_flow ? ACK : RUN;
                    end
                end
            end
            RUN: begin
                cnt_n = cnt;
                if (rst_if.soft_rst_req && !ack) begin
                    part_n  = '0;
                    all_n   = 1'b0;
                    cnt_n   = '0;
                    flow_n  = 1'b1;
                    state_n = HOLD;
                end
            end
            ACK: begin
                cnt_n = cnt;
                if (!rst_if.soft_rst_req) begin
                    ack_n   = 1'b0;
                    flow_n  = 1'b0;
                    state_n = RUN;
                end
            end
            default: state_n = HOLD;
        endcase
    end

    assign rst_if.part_rstn    = test_mode ? {NUM_PART{nvdla_core_rstn}} : part_rstn_q;
    assign rst_if.soft_rst_ack = ack;
    assign rst_if.seq_busy     = (state != RUN);
    assign rst_if.all_released = all_rel;

endmodule

// File: tb/tb_nv_nvdla_partition_reset_seq.sv
// Directed vector bench for the partition reset sequencer (default and single-partition builds).
`timescale 1ns/1ps
module tb_nv_nvdla_partition_reset_seq;

    typedef struct {
        int         off;
        logic [3:0] part;
        logic       all_rel;
        logic       busy;
        logic       ack;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic test_mode = 1'b0;
    logic rst1_n = 1'b0;
    logic tm1 = 1'b0;
    int   edge_cnt = 0;
    int   n_chk = 0;
    int   n_err = 0;
    int   base;
    vec_t pon_tab[$];
    vec_t soft_tab[$];

    nv_nvdla_partition_reset_seq_if #(.NUM_PART(4)) if0 ();
    nv_nvdla_partition_reset_seq_if #(.NUM_PART(1)) if1 ();

    nv_nvdla_partition_reset_seq #(.NUM_PART(4), .HOLD_MIN(16), .STAGGER(8)) u0 (
        .nvdla_clk       (clk),
        .nvdla_core_rstn (rst_n),
        .test_mode       (test_mode),
        .rst_if          (if0.slave)
    );

    nv_nvdla_partition_reset_seq #(.NUM_PART(1), .HOLD_MIN(2), .STAGGER(1)) u1 (
        .nvdla_clk       (clk),
        .nvdla_core_rstn (rst1_n),
        .test_mode       (tm1),
        .rst_if          (if1.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
        edge_cnt++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk0(input string tag, input logic [3:0] part, input logic all_rel,
                        input logic busy, input logic ack);
        chk({tag, " part"}, 32'(if0.part_rstn), 32'(part));
        chk({tag, " all"},  32'(if0.all_released), 32'(all_rel));
        chk({tag, " busy"}, 32'(if0.seq_busy), 32'(busy));
        chk({tag, " ack"},  32'(if0.soft_rst_ack), 32'(ack));
    endtask

    task automatic run_tab(input vec_t tab[$], input int b, input string tag);
        for (int i = 0; i < tab.size(); i++) begin
            while (edge_cnt < b + tab[i].off) tick();
            chk0($sformatf("%s@%0d", tag, tab[i].off), tab[i].part, tab[i].all_rel,
                 tab[i].busy, tab[i].ack);
        end
    endtask

    task automatic reset0();
        rst_n = 1'b0;
        tick();
        tick();
        chk0("in_reset", 4'b0000, 1'b0, 1'b1, 1'b0);
        rst_n = 1'b1;
        edge_cnt = 0;
    endtask

    initial begin
        pon_tab.push_back('{1,  4'b0000, 1'b0, 1'b1, 1'b0});
        pon_tab.push_back('{15, 4'b0000, 1'b0, 1'b1, 1'b0});
        pon_tab.push_back('{16, 4'b0001, 1'b0, 1'b1, 1'b0});
        pon_tab.push_back('{23, 4'b0001, 1'b0, 1'b1, 1'b0});
        pon_tab.push_back('{24, 4'b0011, 1'b0, 1'b1, 1'b0});
        pon_tab.push_back('{31, 4'b0011, 1'b0, 1'b1, 1'b0});
        pon_tab.push_back('{32, 4'b0111, 1'b0, 1'b1, 1'b0});
        pon_tab.push_back('{39, 4'b0111, 1'b0, 1'b1, 1'b0});
        pon_tab.push_back('{40, 4'b1111, 1'b1, 1'b0, 1'b0});

        soft_tab.push_back('{0,  4'b0000, 1'b0, 1'b1, 1'b0});
        soft_tab.push_back('{16, 4'b0000, 1'b0, 1'b1, 1'b0});
        soft_tab.push_back('{17, 4'b0001, 1'b0, 1'b1, 1'b0});
        soft_tab.push_back('{24, 4'b0001, 1'b0, 1'b1, 1'b0});
        soft_tab.push_back('{25, 4'b0011, 1'b0, 1'b1, 1'b0});
        soft_tab.push_back('{33, 4'b0111, 1'b0, 1'b1, 1'b0});
        soft_tab.push_back('{40, 4'b0111, 1'b0, 1'b1, 1'b0});
        soft_tab.push_back('{41, 4'b1111, 1'b1, 1'b1, 1'b1});

        if0.soft_rst_req = 1'b0;
        if1.soft_rst_req = 1'b0;

        // Test 1: power-on
        reset0();
        run_tab(pon_tab, 0, "pon");
        while (edge_cnt < 45) tick();
        chk0("pon@45", 4'b1111, 1'b1, 1'b0, 1'b0);

        // Test 2: soft reset from RUN, held until ack, then dropped
        if0.soft_rst_req = 1'b1;
        base = edge_cnt + 1;
        run_tab(soft_tab, base, "soft");
        tick(); tick(); tick();
        chk0("soft_hold_ack", 4'b1111, 1'b1, 1'b1, 1'b1);
        if0.soft_rst_req = 1'b0;
        tick();
        chk0("soft_drop", 4'b1111, 1'b1, 1'b0, 1'b0);

        // Request dropped during HOLD: sequence completes, ack lasts exactly one cycle
        tick();
        if0.soft_rst_req = 1'b1;
        base = edge_cnt + 1;
        while (edge_cnt < base + 5) tick();
        if0.soft_rst_req = 1'b0;
        chk0("early_drop@5", 4'b0000, 1'b0, 1'b1, 1'b0);
        while (edge_cnt < base + 40) tick();
        chk0("early_drop@40", 4'b0111, 1'b0, 1'b1, 1'b0);
        tick();
        chk0("early_drop@41", 4'b1111, 1'b1, 1'b1, 1'b1);
        tick();
        chk0("early_drop@42", 4'b1111, 1'b1, 1'b0, 1'b0);
        tick();
        chk0("early_drop@43", 4'b1111, 1'b1, 1'b0, 1'b0);

        // Test 3: request held high from reset
        if0.soft_rst_req = 1'b1;
        reset0();
        run_tab(pon_tab, 0, "req_pon");
        run_tab(soft_tab, 41, "req_soft");
        if0.soft_rst_req = 1'b0;
        tick();
        chk0("req_drop", 4'b1111, 1'b1, 1'b0, 1'b0);

        // Test 4: async reset mid-REL
        reset0();
        while (edge_cnt < 26) tick();
        chk0("midrel", 4'b0011, 1'b0, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk0("async_rst", 4'b0000, 1'b0, 1'b1, 1'b0);
        #2;
        rst_n = 1'b1;
        edge_cnt = 0;
        run_tab(pon_tab, 0, "rerun");

        // Test 5: test_mode bypass
        tick();
        test_mode = 1'b1;
        rst_n = 1'b0;
        #1 chk("tm_low",   32'(if0.part_rstn), 32'h0);
        rst_n = 1'b1;
        #1 chk("tm_high",  32'(if0.part_rstn), 32'hf);
        rst_n = 1'b0;
        #1 chk("tm_low2",  32'(if0.part_rstn), 32'h0);
        rst_n = 1'b1;
        edge_cnt = 0;
        #1 chk("tm_high2", 32'(if0.part_rstn), 32'hf);
        test_mode = 1'b0;
        #1 chk("tm_off",   32'(if0.part_rstn), 32'h0);
        while (edge_cnt < 16) tick();
        chk0("tm_reg16", 4'b0001, 1'b0, 1'b1, 1'b0);
        test_mode = 1'b1;
        #1 chk0("tm_on16", 4'b1111, 1'b0, 1'b1, 1'b0);
        test_mode = 1'b0;
        #1 chk("tm_off16", 32'(if0.part_rstn), 32'h1);

        // Test 6: single partition, HOLD_MIN=2, STAGGER=1
        tick();
        rst1_n = 1'b0;
        tick();
        chk("p1_rst part", 32'(if1.part_rstn), 32'h0);
        chk("p1_rst busy", 32'(if1.seq_busy), 32'h1);
        rst1_n = 1'b1;
        edge_cnt = 0;
        tick();
        chk("p1@1 part", 32'(if1.part_rstn), 32'h0);
        chk("p1@1 busy", 32'(if1.seq_busy), 32'h1);
        tick();
        chk("p1@2 part", 32'(if1.part_rstn), 32'h1);
        chk("p1@2 all",  32'(if1.all_released), 32'h1);
        chk("p1@2 busy", 32'(if1.seq_busy), 32'h0);
        chk("p1@2 ack",  32'(if1.soft_rst_ack), 32'h0);
        if1.soft_rst_req = 1'b1;
        tick();
        chk("p1_soft@0 part", 32'(if1.part_rstn), 32'h0);
        chk("p1_soft@0 busy", 32'(if1.seq_busy), 32'h1);
        tick();
        tick();
        chk("p1_soft@2 part", 32'(if1.part_rstn), 32'h0);
        tick();
        chk("p1_soft@3 part", 32'(if1.part_rstn), 32'h1);
        chk("p1_soft@3 ack",  32'(if1.soft_rst_ack), 32'h1);
        chk("p1_soft@3 all",  32'(if1.all_released), 32'h1);
        if1.soft_rst_req = 1'b0;
        tick();
        chk("p1_drop ack",  32'(if1.soft_rst_ack), 32'h0);
        chk("p1_drop busy", 32'(if1.seq_busy), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
